lock_ctrl: RTL and testbench

- Sequencing controller for the 6-digit combination lock. Accepts one BCD digit per `enter` strobe and compares it against a stored, re-programmable code.
- Tracks consecutive failed attempts and enforces a timed lockout.
- Tells the HEX display driver which message to show. Sits between the switch/key front end and the existing seven-segment driver.

---
 rtl/lock_pkg.sv | 44 ++++
 rtl/lock_ctrl_if.sv | 34 +++
 rtl/lock_ctrl_lockout_timer.sv | 45 ++++
 rtl/lock_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lock_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lock_pkg
// Description : Shared types and helpers for the combination-lock controller.
//               Holds the FSM state encoding, the display message encoding
//               consumed by the seven-segment driver, the reset code, and
//               helpers that locate one BCD digit inside a packed code word.
//               Digit 0 is the most significant nibble of the code word.
// Revision    : 1.0 - initial release
// ============================================================================
package lock_pkg;

    localparam int          CODE_DIGITS  = 6;
    localparam logic [23:0] DEFAULT_CODE = 24'h722297;

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        OPEN    = 3'd1,
        CLOSED  = 3'd2,
        LOCKOUT = 3'd3,
        PROG    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        DISP_DIGIT  = 3'd0,
        DISP_ERR    = 3'd1,
        DISP_OPEN   = 3'd2,
        DISP_CLOSED = 3'd3
    } disp_t;

    // Bit position of the LSB of digit idx within a code of 'digits' nibbles.
    function automatic int digit_lsb(input int digits, input logic [2:0] idx);
        return 4 * (digits - 1 - int'(idx));
    endfunction

    // Digit idx of a code word, zero-extended to 32 bits by the caller.
    function automatic logic [3:0] digit_at(input logic [31:0] code,
                                            input int digits,
                                            input logic [2:0] idx);
        return code[digit_lsb(digits, idx) +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lock_ctrl_if
// Description : Front-end/display bundle of the combination lock.
//               Inputs  : digit_in[3:0], enter, relock, prog_req (strobes)
//               Outputs : disp_mode[2:0], unlocked, locked_out,
//                         fail_cnt[1:0], digit_idx[2:0]
//               master = switch/key front end, slave = lock_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface lock_ctrl_if;

    logic [3:0]      digit_in;
    logic            enter;
    logic            relock;
    logic            prog_req;
    lock_pkg::disp_t disp_mode;
    logic            unlocked;
    logic            locked_out;
    logic [1:0]      fail_cnt;
    logic [2:0]      digit_idx;

    modport master (
        output digit_in, enter, relock, prog_req,
        input  disp_mode, unlocked, locked_out, fail_cnt, digit_idx
    );

    modport slave (
        input  digit_in, enter, relock, prog_req,
        output disp_mode, unlocked, locked_out, fail_cnt, digit_idx
    );

endinterface
`default_nettype wire

// File: rtl/lock_ctrl_lockout_timer.sv
`default_nettype none
// ============================================================================
// Module      : lockout_timer
// Description : Down-counter for the lockout period. load has priority over
//               dec; the count holds at zero. zero is decoded from the
//               registered count.
//               Ports: clk, rst (async active-low), load, load_val[WIDTH-1:0],
//                      dec, zero
// Revision    : 1.0 - initial release
// ============================================================================
module lockout_timer #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             dec,
    output logic                  zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lock_ctrl
// Description : Sequencing controller for the 6-digit combination lock.
//               Compares entered BCD digits against a re-programmable code,
//               counts consecutive failures, enforces a timed lockout and
//               selects the message for the HEX display driver.
//               Ports: clk, rst (async active-low), bus (lock_ctrl_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module lock_ctrl #(
    parameter int                  DIGITS       = 6,
    parameter int                  MAX_FAIL     = 3,
    parameter int                  LOCKOUT_CYC  = 16,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 24'h722297
) (
    input  wire logic  clk,
    input  wire logic  rst,
    lock_ctrl_if.slave bus
);

    import lock_pkg::*;

    localparam int CW = 4 * DIGITS;
    localparam int TW = $clog2(LOCKOUT_CYC);

    state_t        state_q,     state_d;
    logic [2:0]    digit_idx_q, digit_idx_d;
    logic          mismatch_q,  mismatch_d;
    logic [1:0]    fail_cnt_q,  fail_cnt_d;
    logic [CW-1:0] code_q,      code_d;
    logic [CW-1:0] shadow_q,    shadow_d;

    logic          accept;
    logic          last_digit;
    logic          mismatch_new;
    logic          timer_load;
    logic          timer_zero;

    assign accept       = bus.enter && (bus.digit_in <= 4'd9);
    assign last_digit   = (int'(digit_idx_q) == DIGITS - 1);
    assign mismatch_new = mismatch_q |
                          (bus.digit_in != digit_at(32'(code_q), DIGITS, digit_idx_q));

    lockout_timer #(
        .WIDTH (TW)
    ) u_lockout_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TW'(LOCKOUT_CYC - 1)),
        .dec      (state_q == LOCKOUT),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d     = state_q;
        digit_idx_d = digit_idx_q;
        mismatch_d  = mismatch_q;
        fail_cnt_d  = fail_cnt_q;
        code_d      = code_q;
        shadow_d    = shadow_q;
        timer_load  = 1'b0;

        case (state_q)
            ENTRY: begin
                if (bus.relock) begin
                    digit_idx_d = '0;
                    mismatch_d  = 1'b0;
                end else if (accept) begin
                    if (last_digit) begin
                        // Verdict uses the mismatch including this digit.
                        digit_idx_d = '0;
                        mismatch_d  = 1'b0;
                        if (!mismatch_new) begin
                            state_d    = OPEN;
                            fail_cnt_d = '0;
                        end else if (int'(fail_cnt_q) + 1 == MAX_FAIL) begin
                            state_d    = LOCKOUT;
                            timer_load = 1'b1;
                            fail_cnt_d = 2'(MAX_FAIL);
                        end else begin
                            state_d    = CLOSED;
                            fail_cnt_d = fail_cnt_q + 2'd1;
                        end
                    end else begin
                        digit_idx_d = digit_idx_q + 3'd1;
                        mismatch_d  = mismatch_new;
                    end
                end
            end
            OPEN: begin
                if (bus.relock) begin
                    state_d = ENTRY;
                end else if (bus.prog_req) begin
                    state_d     = PROG;
                    digit_idx_d = '0;
                end
            end
            PROG: begin
                if (bus.relock) begin
                    state_d     = ENTRY;
                    digit_idx_d = '0;
                end else if (accept) begin
                    shadow_d[digit_lsb(DIGITS, digit_idx_q) +: 4] = bus.digit_in;
                    if (last_digit) begin
                        code_d      = shadow_d;
                        state_d     = ENTRY;
                        digit_idx_d = '0;
                    end else begin
                        digit_idx_d = digit_idx_q + 3'd1;
                    end
                end
            end
            CLOSED: begin
                if (bus.relock) begin
                    state_d = ENTRY;
                end
            end
            LOCKOUT: begin
                if (timer_zero) begin
                    state_d    = ENTRY;
                    fail_cnt_d = '0;
                end
            end
            default: begin
                state_d     = ENTRY;
                digit_idx_d = '0;
                mismatch_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ENTRY;
            digit_idx_q <= '0;
            mismatch_q  <= 1'b0;
            fail_cnt_q  <= '0;
            code_q      <= DEFAULT_CODE;
            shadow_q    <= DEFAULT_CODE;
        end else begin
            state_q     <= state_d;
            digit_idx_q <= digit_idx_d;
            mismatch_q  <= mismatch_d;
            fail_cnt_q  <= fail_cnt_d;
            code_q      <= code_d;
            shadow_q    <= shadow_d;
        end
    end

    always_comb begin
        case (state_q)
            ENTRY, PROG: bus.disp_mode = (bus.digit_in > 4'd9) ? DISP_ERR : DISP_DIGIT;
            OPEN:        bus.disp_mode = DISP_OPEN;
            default:     bus.disp_mode = DISP_CLOSED;
        endcase
    end

    assign bus.unlocked   = (state_q == OPEN);
    assign bus.locked_out = (state_q == LOCKOUT);
    assign bus.fail_cnt   = fail_cnt_q;
    assign bus.digit_idx  = digit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_ctrl
// Description : Self-checking bench for lock_ctrl. A reference model predicts
//               the outputs of every cycle; predictions are queued when the
//               stimulus is driven and popped after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_ctrl;

    import lock_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lock_ctrl_if bus ();

    lock_ctrl #(
        .DIGITS       (6),
        .MAX_FAIL     (3),
        .LOCKOUT_CYC  (16),
        .DEFAULT_CODE (24'h722297)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0] disp;
        logic       unl;
        logic       lko;
        logic [1:0] fc;
        logic [2:0] idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    state_t     m_st;
    int         m_idx;
    bit         m_mm;
    int         m_fail;
    int         m_tmr;
    logic [3:0] m_code[6];
    logic [3:0] m_sh[6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        logic [23:0] c;
        c      = 24'h722297;
        m_st   = ENTRY;
        m_idx  = 0;
        m_mm   = 0;
        m_fail = 0;
        m_tmr  = 0;
        for (int i = 0; i < 6; i++) m_code[i] = c[23-4*i -: 4];
    endtask

    function automatic logic [2:0] m_disp(input logic [3:0] d);
        if (m_st == ENTRY || m_st == PROG) return (d > 9) ? 3'd1 : 3'd0;
        if (m_st == OPEN) return 3'd2;
        return 3'd3;
    endfunction

    task automatic m_step(input bit en, input bit rl, input bit pr, input logic [3:0] d);
        bit acc;
        bit wrong;
        acc = en && (d <= 9);
        case (m_st)
            ENTRY: begin
                if (rl) begin
                    m_idx = 0; m_mm = 0;
                end else if (acc) begin
                    wrong = m_mm || (d != m_code[m_idx]);
                    if (m_idx == 5) begin
                        m_idx = 0; m_mm = 0;
                        if (!wrong) begin
                            m_st = OPEN; m_fail = 0;
                        end else if (m_fail + 1 == 3) begin
                            m_st = LOCKOUT; m_tmr = 15; m_fail = 3;
                        end else begin
                            m_st = CLOSED; m_fail++;
                        end
                    end else begin
                        m_idx++; m_mm = wrong;
                    end
                end
            end
            OPEN: begin
                if (rl) m_st = ENTRY;
                else if (pr) begin m_st = PROG; m_idx = 0; end
            end
            PROG: begin
                if (rl) begin
                    m_st = ENTRY; m_idx = 0;
                end else if (acc) begin
                    m_sh[m_idx] = d;
                    if (m_idx == 5) begin
                        for (int i = 0; i < 6; i++) m_code[i] = m_sh[i];
                        m_st = ENTRY; m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            CLOSED: if (rl) m_st = ENTRY;
            LOCKOUT: begin
                if (m_tmr == 0) begin m_st = ENTRY; m_fail = 0; end
                else m_tmr--;
            end
            default: m_st = ENTRY;
        endcase
    endtask

    // One clock cycle of stimulus with full prediction/compare.
    task automatic step(input bit en, input bit rl, input bit pr, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        bus.enter    = en;
        bus.relock   = rl;
        bus.prog_req = pr;
        bus.digit_in = d;
        #1;
        check("disp_pre", bus.disp_mode, m_disp(d));
        m_step(en, rl, pr, d);
        e.disp = m_disp(d);
        e.unl  = (m_st == OPEN);
        e.lko  = (m_st == LOCKOUT);
        e.fc   = 2'(m_fail);
        e.idx  = 3'(m_idx);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("disp",       bus.disp_mode,  e.disp);
        check("unlocked",   bus.unlocked,   e.unl);
        check("locked_out", bus.locked_out, e.lko);
        check("fail_cnt",   bus.fail_cnt,   e.fc);
        check("digit_idx",  bus.digit_idx,  e.idx);
    endtask

    task automatic enter_code(input logic [23:0] c);
        for (int i = 0; i < 6; i++) step(1, 0, 0, c[23-4*i -: 4]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst          = 1'b0;
        bus.enter    = 1'b0;
        bus.relock   = 1'b0;
        bus.prog_req = 1'b0;
        bus.digit_in = 4'd0;
        #1;
        m_reset();
        check("rst_unlocked",   bus.unlocked,   0);
        check("rst_locked_out", bus.locked_out, 0);
        check("rst_fail_cnt",   bus.fail_cnt,   0);
        check("rst_digit_idx",  bus.digit_idx,  0);
        check("rst_disp",       bus.disp_mode,  DISP_DIGIT);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int n_lock;

    initial begin
        bus.enter    = 1'b0;
        bus.relock   = 1'b0;
        bus.prog_req = 1'b0;
        bus.digit_in = 4'd0;
        m_reset();
        do_reset();

        // Correct default code opens
        enter_code(24'h722297);
        check("open_unlocked", bus.unlocked, 1);
        check("open_disp", bus.disp_mode, DISP_OPEN);
        step(0, 1, 0, 0);

        // Wrong last digit closes; bad digit shows ERR and is ignored
        enter_code(24'h722291);
        check("closed_fail1", bus.fail_cnt, 1);
        check("closed_disp", bus.disp_mode, DISP_CLOSED);
        step(1, 0, 1, 7);
        step(0, 1, 0, 0);
        step(0, 0, 0, 11);
        check("err_disp", bus.disp_mode, DISP_ERR);
        step(1, 0, 0, 11);
        check("bad_digit_idx", bus.digit_idx, 0);
        step(1, 0, 0, 5);
        check("good_digit_idx", bus.digit_idx, 1);
        step(0, 1, 0, 0);
        check("relock_idx", bus.digit_idx, 0);

        // Second and third failures -> lockout of exactly 16 cycles
        enter_code(24'h000000);
        step(0, 1, 0, 0);
        enter_code(24'h000000);
        check("lockout_enter", bus.locked_out, 1);
        check("lockout_fail", bus.fail_cnt, 3);
        n_lock = 0;
        while (bus.locked_out && n_lock < 40) begin
            n_lock++;
            step(1, n_lock[0], 1, 4'(n_lock % 10));
        end
        check("lockout_cycles", n_lock, 16);
        check("lockout_exit_fail", bus.fail_cnt, 0);

        // Reprogram to 123456
        enter_code(24'h722297);
        step(0, 0, 1, 0);
        enter_code(24'h123456);
        check("prog_done_locked", bus.unlocked, 0);
        enter_code(24'h722297);
        check("old_code_fails", bus.fail_cnt, 1);
        step(0, 1, 0, 0);
        enter_code(24'h123456);
        check("new_code_opens", bus.unlocked, 1);
        check("new_code_fail0", bus.fail_cnt, 0);

        // Reset reverts code
        do_reset();
        enter_code(24'h722297);
        check("revert_opens", bus.unlocked, 1);

        // Aborted programming, relock+final digit, relock+prog_req
        step(0, 0, 1, 0);
        step(1, 0, 0, 1); step(1, 0, 0, 2); step(1, 0, 0, 3);
        step(0, 1, 0, 0);
        enter_code(24'h722297);
        check("abort_keeps_code", bus.unlocked, 1);
        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 4'(i + 1));
        step(1, 1, 0, 6);
        enter_code(24'h722297);
        check("relock_final_no_commit", bus.unlocked, 1);
        step(0, 1, 1, 0);
        check("relock_wins", bus.unlocked, 0);
        enter_code(24'h722297);
        check("relock_wins_entry", bus.unlocked, 1);
        step(0, 1, 0, 0);

        // Reset mid-entry and mid-programming
        step(1, 0, 0, 7); step(1, 0, 0, 2); step(1, 0, 0, 2);
        do_reset();
        enter_code(24'h722297);
        step(0, 0, 1, 0);
        step(1, 0, 0, 9); step(1, 0, 0, 9); step(1, 0, 0, 9);
        do_reset();
        enter_code(24'h722297);
        check("midprog_reset_code", bus.unlocked, 1);
        step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
